// File: rtl/nibble_loader_if.sv
// nibble_loader_if
//   Host-side word handshake between a host (master) and the nibble loader
//   (slave).
//   word_in    : 16-bit vector to send, lanes [3:0],[7:4],[11:8],[15:12]
//   word_sel   : 1 = weights vector, 0 = inputs vector
//   word_valid : host offers word_in/word_sel
//   word_ready : loader accepts when word_valid is also high
interface nibble_loader_if;
  logic [15:0] word_in;
  logic        word_sel;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word_in,
    output word_sel,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_sel,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/nibble_loader.sv
// nibble_loader
//   Serializes 16-bit weight/input vectors into four 4-bit nibbles (LSB
//   nibble first) for the neuron core's nibble-serial load port, and
//   signals when a full weights/inputs pair has been delivered.
// Ports:
//   clk        : single clock, rising edge
//   rst_n      : synchronous reset, ACTIVE-HIGH (name matches the core port)
//   host       : word handshake (nibble_loader_if.slave)
//   nib_out    : nibble to core ui_in[3:0]
//   nib_sel    : select to core uio_in[7], 1 = weights
//   nib_we     : nibble strobe, core shifts one nibble per high cycle
//   busy       : high while shifting or in the post-word gap
//   pair_done  : one-cycle pulse when a weights and an inputs word completed
//   pair_count : pair_done pulses since reset, wrapping
// All outputs are registered.
module nibble_loader #(
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_loader_if.slave   host,
  output logic [3:0]       nib_out,
  output logic             nib_sel,
  output logic             nib_we,
  output logic             busy,
  output logic             pair_done,
  output logic [CNT_W-1:0] pair_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic             HAS_GAP    = (GAP_CYCLES != 0);
  localparam int unsigned      GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [3:0]       GAP_LAST   = GAP_LAST_I[3:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [1:0]       beat;
  logic [1:0]       beat_next;
  logic [15:0]      shreg;
  logic [15:0]      shreg_next;
  logic [3:0]       gap_cnt;
  logic [3:0]       gap_cnt_next;
  logic             have_w;
  logic             have_w_next;
  logic             have_i;
  logic             have_i_next;
  logic             ready;
  logic             ready_next;
  logic [3:0]       nib_out_next;
  logic             nib_sel_next;
  logic             nib_we_next;
  logic             busy_next;
  logic             pair_done_next;
  logic [CNT_W-1:0] pair_count_next;

  logic accept;
  logic last_beat;
  logic set_w;
  logic set_i;
  logic pair_hit;

  assign accept          = host.word_valid & ready;
  assign last_beat       = (state == SHIFT) && (beat == 2'd3);
  assign host.word_ready = ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (beat == 2'd3) begin
          if (HAS_GAP) begin
            state_next = GAP;
          end else if (accept) begin
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = SHIFT;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          state_next = GAP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Next values for the datapath registers and the registered outputs
  always_comb begin
    shreg_next   = shreg;
    beat_next    = beat;
    nib_out_next = nib_out;
    nib_sel_next = nib_sel;
    nib_we_next  = 1'b0;

    // shreg keeps only the nibbles not yet presented on nib_out
    if (accept) begin
      shreg_next   = {4'd0, host.word_in[15:4]};
      beat_next    = 2'd0;
      nib_out_next = host.word_in[3:0];
      nib_sel_next = host.word_sel;
      nib_we_next  = 1'b1;
    end else if ((state == SHIFT) && (beat != 2'd3)) begin
      shreg_next   = {4'd0, shreg[15:4]};
      beat_next    = beat + 2'd1;
      nib_out_next = shreg[3:0];
      nib_we_next  = 1'b1;
    end else begin
      // GAP/IDLE: nib_out and nib_sel hold, strobe low
      nib_we_next  = 1'b0;
    end

    if (state == GAP) begin
      gap_cnt_next = gap_cnt + 4'd1;
    end else begin
      gap_cnt_next = 4'd0;
    end

    // nib_sel still describes the finishing word, even if a new one is
    // accepted in this same cycle.
    set_w    = last_beat & nib_sel;
    set_i    = last_beat & ~nib_sel;
    pair_hit = (have_w | set_w) & (have_i | set_i);

    if (pair_hit) begin
      have_w_next     = 1'b0;
      have_i_next     = 1'b0;
      pair_done_next  = 1'b1;
      pair_count_next = pair_count + CNT_ONE;
    end else begin
      have_w_next     = have_w | set_w;
      have_i_next     = have_i | set_i;
      pair_done_next  = 1'b0;
      pair_count_next = pair_count;
    end

    busy_next = (state_next != IDLE);

    // Without a gap, ready is also offered during beat 3 for back-to-back words.
    if (state_next == IDLE) begin
      ready_next = 1'b1;
    end else if (!HAS_GAP && (state_next == SHIFT) && (beat_next == 2'd3)) begin
      ready_next = 1'b1;
    end else begin
      ready_next = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      shreg      <= 16'd0;
      beat       <= 2'd0;
      gap_cnt    <= 4'd0;
      have_w     <= 1'b0;
      have_i     <= 1'b0;
      ready      <= 1'b1;
      nib_out    <= 4'd0;
      nib_sel    <= 1'b0;
      nib_we     <= 1'b0;
      busy       <= 1'b0;
      pair_done  <= 1'b0;
      pair_count <= {CNT_W{1'b0}};
    end else begin
      shreg      <= shreg_next;
      beat       <= beat_next;
      gap_cnt    <= gap_cnt_next;
      have_w     <= have_w_next;
      have_i     <= have_i_next;
      ready      <= ready_next;
      nib_out    <= nib_out_next;
      nib_sel    <= nib_sel_next;
      nib_we     <= nib_we_next;
      busy       <= busy_next;
      pair_done  <= pair_done_next;
      pair_count <= pair_count_next;
    end
  end

endmodule
